// File: rtl/mem_access_unit.sv
// Load/store unit: takes an ALU effective address, runs one request/acknowledge
// data-memory transaction, and returns a lane-steered, sign/zero-extended load result.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata_out,
    output logic        addr_err,
    output logic        bus_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

    localparam logic [8:0] TIMEOUT_CNT = 9'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;          // op[3]=store, op[2]=unsigned, op[1:0]=size
    logic [1:0]  lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        addr_err_q, addr_err_d;
    logic        bus_err_q, bus_err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] maddr_q, maddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        op_ok;
    logic        misaligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;
    logic [8:0]  cnt_inc;

    always_comb begin
        op_ok = 1'b0;
        case (op)
            6'b100000, 6'b100100, 6'b100001, 6'b100101,
            6'b100011, 6'b101000, 6'b101001, 6'b101011: op_ok = 1'b1;
            default: op_ok = 1'b0;
        endcase
    end

    always_comb begin
        misaligned = 1'b0;
        be_calc    = 4'b1111;
        wdata_calc = wdata;
        case (op[1:0])
            2'b00: begin
                be_calc    = 4'b0001 << addr[1:0];
                wdata_calc = {4{wdata[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_calc    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_calc = {2{wdata[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (lo_q)
            2'd0: ld_byte = mem_rdata[7:0];
            2'd1: ld_byte = mem_rdata[15:8];
            2'd2: ld_byte = mem_rdata[23:16];
            2'd3: ld_byte = mem_rdata[31:24];
            default: ld_byte = mem_rdata[7:0];
        endcase
        ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q[1:0])
            2'b00:   ld_val = op_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_val = op_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        lo_d       = lo_q;
        maddr_d    = maddr_q;
        be_d       = be_q;
        mwdata_d   = mwdata_q;
        rdata_d    = rdata_q;
        done_d     = 1'b0;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        req_d      = 1'b0;
        we_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && op_ok) begin
                    op_d     = op[3:0];
                    lo_d     = addr[1:0];
                    maddr_d  = {addr[31:2], 2'b00};
                    be_d     = be_calc;
                    mwdata_d = wdata_calc;
                    if (misaligned) begin
                        state_d    = FIN;
                        done_d     = 1'b1;
                        addr_err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        we_d    = op[3];
                        cnt_d   = 8'd0;
                    end
                end
            end
            REQ: begin
                // An ack on the final allowed cycle still completes normally.
                if (mem_ack) begin
                    state_d = FIN;
                    done_d  = 1'b1;
                    if (!op_q[3]) rdata_d = ld_val;
                end else if (cnt_inc >= TIMEOUT_CNT) begin
                    state_d   = FIN;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc[7:0];
                    req_d = 1'b1;
                    we_d  = we_q;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            bus_err_q  <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            be_q       <= '0;
            mwdata_q   <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            lo_q       <= lo_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            bus_err_q  <= bus_err_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            be_q       <= be_d;
            mwdata_q   <= mwdata_d;
            rdata_q    <= rdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_be    = be_q;
    assign mem_wdata = mwdata_q;
    assign rdata_out = rdata_q;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle load/store unit sitting directly downstream of the ALU: it takes the ALU's effective address (`alu_result` of lb/lbu/lh/lhu/lw/sb/sh/sw) plus the store operand and performs the data-memory transaction over a request/acknowledge bus. It does byte-lane steering, sign/zero extension and alignment checking, and stalls the core via `busy` until the access completes. Its result feeds the register write-back mux.

## Interface
- `TIMEOUT`, default 255: max cycles `mem_req` is held without `mem_ack` before bus error (1..255).
- Clocking and reset: one clock, `clk`; reset `rst` is asynchronous and active-high.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `start`  in  1  one-cycle launch pulse, sampled only in IDLE.
- `op`  in  6  instruction opcode (100000 lb, 100100 lbu, 100001 lh, 100101 lhu, 100011 lw, 101000 sb, 101001 sh, 101011 sw).
- `addr`  in  32  effective byte address from ALU.
- `wdata`  in  32  store data (rt value).
- `busy`  out  1  high whenever state is not IDLE; core stalls.
- `done`  out  1  one-cycle completion pulse.
- `rdata_out`  out  32  formatted load result, valid from `done` until next load completes.
- `addr_err`  out  1  with `done`: misaligned access, no bus cycle issued.
- `bus_err`  out  1  with `done`: timeout expired.
- `mem_req`  out  1  bus request.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address {addr[31:2],2'b00}.
- `mem_be`  out  4  byte enables (bit i = byte lane [8i+7:8i], little-endian).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus acknowledge; `mem_rdata` valid same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States: IDLE, REQ, FIN.
- IDLE: on `start` with a listed opcode: latch op, addr[1:0], bus fields. Misaligned (halfword addr[0]=1, word addr[1:0]≠0) -> FIN with `addr_err`. Otherwise -> REQ. `start` with other opcode ignored; `start` outside IDLE ignored.
- REQ: `mem_req`=1, `mem_addr/mem_be/mem_we/mem_wdata` stable until ack. On `mem_ack` -> FIN, capture load result. Timeout counter clears on REQ entry, increments each cycle without ack; reaching `TIMEOUT` -> FIN with `bus_err`, `mem_req` dropped.
- FIN: `done`=1 for exactly one cycle, then IDLE.
- Stores: sb `mem_wdata`={4{wdata[7:0]}}, `mem_be`=1<<addr[1:0]; sh {2{wdata[15:0]}}, be=addr[1]?1100:0011; sw wdata, be=1111. Loads: `mem_be` as above, `mem_we`=0.
- Loads: lb/lbu select byte mem_rdata[8·addr[1:0]+7 : 8·addr[1:0]], sign/zero extended to 32; lh/lhu select half addr[1]; lw whole word.
- `rdata_out` updates only on acked load; stores and errors leave it unchanged.
- `addr_err` and `bus_err` never both high; both low when `done` low.

## Timing
- Reset: state IDLE; `busy`, `done`, `addr_err`, `bus_err`, `mem_req`, `mem_we`=0; `mem_addr`, `mem_be`, `mem_wdata`, `rdata_out`, timeout counter = 0.
- `start` at cycle 0 -> `mem_req` from cycle 1; ack at cycle k≥1 -> `done` at k+1, IDLE at k+2. Zero-wait memory: total 3 cycles, `busy` high cycles 1-2.
- Misaligned: `done`+`addr_err` at cycle 1, `mem_req` never asserted.
- Timeout: `mem_req` high cycles 1..TIMEOUT, `done`+`bus_err` at TIMEOUT+1. Ack arriving on the timeout cycle wins (normal completion).
- Ack while not in REQ ignored.
- `rst` mid-operation: all outputs return to reset values immediately (asynchronous); pending transaction abandoned.
- All outputs registered.

## Test plan
- sw addr=0x100, wdata=0xDEADBEEF, ack after 2 cycles -> mem_addr=0x100, be=1111, we=1, wdata=0xDEADBEEF; done at cycle 4, no errors.
- lb addr=0x203, mem_rdata=0x80FF1234 (immediate ack) -> be=1000, rdata_out=0xFFFFFF80; same with lbu -> 0x00000080; done at cycle 2.
- sh addr=0x42, wdata=0x0000ABCD -> mem_addr=0x40, be=1100, mem_wdata=0xABCDABCD; lh addr=0x42, rdata=0x9abc0000 -> 0xFFFF9ABC.
- lw addr=0x1001 -> done+addr_err at cycle 1, mem_req never high, rdata_out unchanged.
- lw with mem_ack tied low, TIMEOUT=4 -> mem_req cycles 1-4, done+bus_err cycle 5; then start ignored during busy, new access accepted after IDLE.
- Assert rst at cycle 2 of a pending load -> mem_req/busy low immediately, rdata_out=0; start after release completes normally.
